fml_arb2: RTL



---
 rtl/fml_pkg.sv | 13 +
 rtl/fml_arb2_stats.sv | 32 +++
 rtl/fml_arb2.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fml_pkg.sv
// Shared FML 4x64 definitions: burst length, data/byte-enable widths, arbiter state encoding.
package fml_pkg;

    localparam int unsigned FML_BURST_BEATS = 4;
    localparam int unsigned FML_DW          = 64;
    localparam int unsigned FML_SELW        = 8;

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } fml_state_e;

endpackage

// File: rtl/fml_arb2_stats.sv
// Per-master burst counters for fml_arb2, built only when FML_ARB2_STATS_EN is defined.
module fml_arb2_stats (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        i_ack0,
    input  logic        i_ack1,
    input  logic        i_clr,
    output logic [31:0] o_bursts0,
    output logic [31:0] o_bursts1
);

    logic [31:0] r_bursts0;
    logic [31:0] r_bursts1;

    // Clear takes priority over a coincident forwarded ack.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_bursts0 <= '0;
            r_bursts1 <= '0;
        end else if (i_clr) begin
            r_bursts0 <= '0;
            r_bursts1 <= '0;
        end else begin
            if (i_ack0) r_bursts0 <= r_bursts0 + 32'd1;
            if (i_ack1) r_bursts1 <= r_bursts1 + 32'd1;
        end
    end

    assign o_bursts0 = r_bursts0;
    assign o_bursts1 = r_bursts1;

endmodule

// File: rtl/fml_arb2.sv
// Two-master to one-slave FML 4x64 round-robin burst arbiter.
// Optional per-master burst counters are enabled with `define FML_ARB2_STATS_EN.
module fml_arb2
    import fml_pkg::*;
#(
    parameter int unsigned fml_depth = 26
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,

    input  logic [fml_depth-1:0] m0_adr,
    input  logic                 m0_stb,
    input  logic                 m0_we,
    output logic                 m0_ack,
    input  logic [FML_SELW-1:0]  m0_sel,
    input  logic [FML_DW-1:0]    m0_do,

    input  logic [fml_depth-1:0] m1_adr,
    input  logic                 m1_stb,
    input  logic                 m1_we,
    output logic                 m1_ack,
    input  logic [FML_SELW-1:0]  m1_sel,
    input  logic [FML_DW-1:0]    m1_do,

    output logic [FML_DW-1:0]    m_di,

    output logic [fml_depth-1:0] s_adr,
    output logic                 s_stb,
    output logic                 s_we,
    input  logic                 s_ack,
    output logic [FML_SELW-1:0]  s_sel,
    output logic [FML_DW-1:0]    s_do,
    input  logic [FML_DW-1:0]    s_di
`ifdef FML_ARB2_STATS_EN
    ,
    input  logic                 stats_clr,
    output logic [31:0]          m0_bursts,
    output logic [31:0]          m1_bursts
`endif
);

    localparam int unsigned BEAT_W = $clog2(FML_BURST_BEATS);
    localparam logic [BEAT_W-1:0] TRAIL_BEATS = BEAT_W'(FML_BURST_BEATS - 1);

    fml_state_e        r_state;
    fml_state_e        w_state_nxt;
    logic              r_grant;
    logic              w_grant_nxt;
    logic [BEAT_W-1:0] r_cnt;
    logic [BEAT_W-1:0] w_cnt_nxt;
    logic              w_own_stb;
    logic              w_other_stb;
    logic              w_stb;
    logic              w_ack0;
    logic              w_ack1;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ARB;
            r_grant <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign w_own_stb   = r_grant ? m1_stb : m0_stb;
    assign w_other_stb = r_grant ? m0_stb : m1_stb;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_cnt_nxt   = r_cnt;
        w_stb       = 1'b0;
        w_ack0      = 1'b0;
        w_ack1      = 1'b0;
        unique case (r_state)
            ARB: begin
                w_stb = w_own_stb;
                if (s_ack) begin
                    w_ack0      = ~r_grant;
                    w_ack1      = r_grant;
                    w_state_nxt = BURST;
                    w_cnt_nxt   = TRAIL_BEATS;
                end else if (!w_own_stb && w_other_stb) begin
                    w_grant_nxt = ~r_grant;
                end
            end
            BURST: begin
                // Trailing beats: slave acks here are protocol violations and are dropped.
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == BEAT_W'(1)) begin
                    w_state_nxt = ARB;
                    if (w_other_stb) w_grant_nxt = ~r_grant;
                end
            end
            default: w_state_nxt = ARB;
        endcase
    end

    assign s_stb  = w_stb;
    assign s_adr  = r_grant ? m1_adr : m0_adr;
    assign s_we   = r_grant ? m1_we  : m0_we;
    assign s_sel  = r_grant ? m1_sel : m0_sel;
    assign s_do   = r_grant ? m1_do  : m0_do;
    assign m0_ack = w_ack0;
    assign m1_ack = w_ack1;
    assign m_di   = s_di;

`ifdef FML_ARB2_STATS_EN
    fml_arb2_stats u_stats (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_ack0    (w_ack0),
        .i_ack1    (w_ack1),
        .i_clr     (stats_clr),
        .o_bursts0 (m0_bursts),
        .o_bursts1 (m1_bursts)
    );
`endif

endmodule
